// File: rtl/alu_rr_sched_if.sv
// alu_rr_sched_if: requester request/response channels plus the shared ALU bus
interface alu_rr_sched_if #(parameter int N = 4);
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [3*N-1:0] req_opcode;
  logic [8*N-1:0] req_a;
  logic [8*N-1:0] req_b;
  logic [N-1:0]   rsp_valid;
  logic [N-1:0]   rsp_ready;
  logic [15:0]    rsp_result;
  logic           rsp_err;
  logic [2:0]     alu_opcode;
  logic [7:0]     alu_a;
  logic [7:0]     alu_b;
  logic [15:0]    alu_result;
  logic           alu_valid;
  modport master (
    output req_valid, req_opcode, req_a, req_b, rsp_ready, alu_result, alu_valid,
    input  req_ready, rsp_valid, rsp_result, rsp_err, alu_opcode, alu_a, alu_b
  );
  modport slave (
    input  req_valid, req_opcode, req_a, req_b, rsp_ready, alu_result, alu_valid,
    output req_ready, rsp_valid, rsp_result, rsp_err, alu_opcode, alu_a, alu_b
  );
endinterface

// File: rtl/alu_rr_sched.sv
// alu_rr_sched: round-robin scheduler sharing one registered-latency ALU among N requesters
module alu_rr_sched #(
  parameter int N = 4,
  parameter int CNT_W = 16,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_rr_sched_if.slave    bus,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;
  state_t           r_state, w_next;
  logic [IDX_W-1:0] r_last, r_gnt, w_gnt, w_idx;
  logic             w_found, w_take;
  logic [N-1:0]     w_ready, r_rsp_valid;
  logic [2:0]       r_op;
  logic [7:0]       r_a, r_b;
  logic [15:0]      r_result;
  logic             r_err, r_busy;
  logic [CNT_W-1:0] r_cnt;
  // Scan downward so the last hit is the first valid index after r_last.
  always_comb begin
    w_gnt = r_last;
    w_idx = '0;
    w_found = 1'b0;
    for (int k = N; k >= 1; k--) begin
      w_idx = IDX_W'((int'(r_last) + k) % N);
      if (bus.req_valid[w_idx]) begin
        w_gnt = w_idx;
        w_found = 1'b1;
      end
    end
  end
  always_ff @(posedge clk)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb
    w_next = (r_state == IDLE)    ? (w_found ? ISSUE : IDLE)
           : (r_state == ISSUE)   ? CAPTURE
           : (r_state == CAPTURE) ? RESP
           : (bus.rsp_ready[r_gnt] ? IDLE : RESP);
  always_comb begin
    w_ready = '0;
    w_ready[w_gnt] = (r_state == IDLE) && w_found;
    w_take = (r_state == RESP) && bus.rsp_ready[r_gnt];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last <= IDX_W'(N - 1);
      r_gnt <= '0;
      r_op <= '0;
      r_a <= '0;
      r_b <= '0;
      r_result <= '0;
      r_err <= 1'b0;
      r_rsp_valid <= '0;
      r_busy <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_busy <= w_next != IDLE;
      if (w_ready != '0) begin
        r_gnt <= w_gnt;
        r_op <= bus.req_opcode[3*w_gnt +: 3];
        r_a <= bus.req_a[8*w_gnt +: 8];
        r_b <= bus.req_b[8*w_gnt +: 8];
      end
      if (r_state == CAPTURE) begin
        r_result <= bus.alu_result;
        r_err <= ~bus.alu_valid;
        r_rsp_valid[r_gnt] <= 1'b1;
      end
      if (w_take) begin
        r_rsp_valid <= '0;
        r_last <= r_gnt;
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
  assign bus.req_ready = w_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_result = r_result;
  assign bus.rsp_err = r_err;
  assign bus.alu_opcode = r_op;
  assign bus.alu_a = r_a;
  assign bus.alu_b = r_b;
  assign busy = r_busy;
  assign ops_done = r_cnt;
endmodule

// File: tb/tb_alu_rr_sched.sv
// tb_alu_rr_sched: scoreboard bench with a registered ALU model, directed cases and random traffic
module tb_alu_rr_sched;
  localparam int N = 4;
  localparam int CNT_W = 16;
  typedef struct {int g; logic [15:0] res; logic err; int t;} exp_t;
  typedef struct {logic [2:0] op; logic [7:0] a; logic [7:0] b;} op_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  logic [CNT_W-1:0] ops_done;
  int total = 0, bad = 0, cyc = 0, resp_cnt = 0, model_cnt = 0, m_last = N - 1;
  int cur_len = 0, last_len = 0, last_g = -1, g;
  logic [15:0] last_res;
  logic last_err;
  logic [16:0] r;
  logic [N-1:0] e_rdy, e_rsp;
  bit inflight = 1'b0;
  bit acc [N];
  exp_t sb [$];
  op_t stim [N][$];
  int grant_log [$];
  int acc_cyc [$];
  alu_rr_sched_if #(.N(N)) bus ();
  alu_rr_sched #(.N(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .ops_done(ops_done)
  );
  always #5 clk = ~clk;
  function automatic logic [16:0] alu_ref(logic [2:0] op, logic [7:0] a, logic [7:0] b);
    logic [15:0] x = {8'h00, a};
    logic [15:0] y = {8'h00, b};
    case (op)
      3'd0: return {1'b1, x + y};
      3'd1: return {1'b1, x - y};
      3'd2: return {1'b1, x & y};
      3'd3: return {1'b1, x | y};
      3'd4: return {1'b1, x ^ y};
      3'd5: return {1'b1, x * y};
      default: return {1'b0, 16'hDEAD};
    endcase
  endfunction
  function automatic int rr(int last, logic [N-1:0] v);
    for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction
  // Shared ALU: one-cycle registered latency, active-high reset
  logic alu_rst;
  assign alu_rst = ~rst_n;
  always @(posedge clk)
    if (alu_rst) {bus.alu_valid, bus.alu_result} <= '0;
    else {bus.alu_valid, bus.alu_result} <= alu_ref(bus.alu_opcode, bus.alu_a, bus.alu_b);
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, exp);
    end
  endtask
  task automatic chk_zero(string name);
    chk({name, "_ctl"}, {bus.req_ready, bus.rsp_valid, bus.rsp_err, busy, bus.alu_opcode}, 0);
    chk({name, "_dat"}, {bus.alu_a, bus.alu_b, bus.rsp_result}, 0);
    chk({name, "_cnt"}, ops_done, 0);
  endtask
  // Requesters present the head of their queue and retire it once accepted
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        if (stim[i].size() > 0) void'(stim[i].pop_front());
        acc[i] = 1'b0;
      end
      bus.req_valid[i] = stim[i].size() > 0;
      if (stim[i].size() > 0) begin
        bus.req_opcode[3*i +: 3] = stim[i][0].op;
        bus.req_a[8*i +: 8] = stim[i][0].a;
        bus.req_b[8*i +: 8] = stim[i][0].b;
      end else begin
        bus.req_opcode[3*i +: 3] = 3'd0;
        bus.req_a[8*i +: 8] = 8'd0;
        bus.req_b[8*i +: 8] = 8'd0;
      end
    end
  end
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      sb.delete();
      inflight = 1'b0;
      m_last = N - 1;
      model_cnt = 0;
      cur_len = 0;
      for (int i = 0; i < N; i++) acc[i] = 1'b0;
    end else begin
      chk("busy", busy, inflight);
      chk("ops_done", ops_done, model_cnt);
      chk("onehot", $countones(bus.req_ready) <= 1 && $countones(bus.rsp_valid) <= 1, 1);
      e_rdy = '0;
      g = inflight ? -1 : rr(m_last, bus.req_valid);
      if (g >= 0) e_rdy[g] = 1'b1;
      chk("req_ready", bus.req_ready, e_rdy);
      if (g >= 0) begin
        r = alu_ref(bus.req_opcode[3*g +: 3], bus.req_a[8*g +: 8], bus.req_b[8*g +: 8]);
        sb.push_back('{g, r[15:0], ~r[16], cyc});
        inflight = 1'b1;
        acc[g] = 1'b1;
        grant_log.push_back(g);
        acc_cyc.push_back(cyc);
      end
      e_rsp = '0;
      if (sb.size() > 0 && cyc >= sb[0].t + 3) e_rsp[sb[0].g] = 1'b1;
      chk("rsp_valid", bus.rsp_valid, e_rsp);
      if (e_rsp != '0) begin
        cur_len++;
        chk("rsp_result", bus.rsp_result, sb[0].res);
        chk("rsp_err", bus.rsp_err, sb[0].err);
        if (bus.rsp_ready[sb[0].g]) begin
          last_res = bus.rsp_result;
          last_err = bus.rsp_err;
          last_g = sb[0].g;
          last_len = cur_len;
          cur_len = 0;
          m_last = sb[0].g;
          model_cnt++;
          resp_cnt++;
          inflight = 1'b0;
          void'(sb.pop_front());
        end
      end
    end
  end
  task automatic push(int i, logic [2:0] op, logic [7:0] a, logic [7:0] b);
    stim[i].push_back('{op, a, b});
  endtask
  task automatic wait_resp(int n);
    int k = 0;
    while (resp_cnt < n && k < 300) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("resp_timeout", resp_cnt >= n, 1);
  endtask
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) stim[i].delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  initial begin
    int base, k, ri;
    int rr_exp [5] = '{0, 1, 2, 3, 0};
    bus.req_valid = '0;
    bus.req_opcode = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.rsp_ready = '0;
    repeat (2) @(negedge clk);
    #1 chk_zero("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.rsp_ready = '1;
    // single op from requester 2
    base = resp_cnt;
    grant_log.delete();
    push(2, 3'd0, 8'hFF, 8'h01);
    wait_resp(base + 1);
    chk("single_g", last_g, 2);
    chk("single_res", last_res, 16'h0100);
    chk("single_err", last_err, 0);
    @(negedge clk);
    #1 chk("single_cnt", ops_done, 1);
    // round robin with all requesters busy
    do_reset();
    base = resp_cnt;
    grant_log.delete();
    acc_cyc.delete();
    push(0, 3'd0, 8'h11, 8'h22);
    push(1, 3'd1, 8'h50, 8'h60);
    push(2, 3'd2, 8'hF0, 8'h0F);
    push(3, 3'd3, 8'hA0, 8'h0A);
    push(0, 3'd4, 8'hFF, 8'h0F);
    wait_resp(base + 5);
    @(negedge clk);
    #1 chk("rr_cnt", ops_done, 5);
    chk("rr_n", grant_log.size(), 5);
    if (grant_log.size() == 5)
      for (int i = 0; i < 5; i++) begin
        chk("rr_order", grant_log[i], rr_exp[i]);
        if (i > 0) chk("rr_gap", acc_cyc[i] - acc_cyc[i-1], 4);
      end
    // multiply under backpressure; other ready bits must be ignored
    base = resp_cnt;
    bus.rsp_ready = 4'b1110;
    push(0, 3'd5, 8'hFF, 8'hFF);
    k = 0;
    while (bus.rsp_valid == '0 && k < 50) begin
      @(negedge clk);
      #1;
      k++;
    end
    push(1, 3'd0, 8'h12, 8'h34);
    repeat (5) @(posedge clk);
    #1 bus.rsp_ready = '1;
    wait_resp(base + 1);
    chk("bp_len", last_len, 6);
    chk("bp_res", last_res, 16'hFE01);
    chk("bp_g", last_g, 0);
    wait_resp(base + 2);
    chk("bp_next", last_res, 16'h0046);
    // illegal opcode then a legal AND
    base = resp_cnt;
    push(1, 3'd7, 8'hAA, 8'h55);
    wait_resp(base + 1);
    chk("ill_res", last_res, 16'hDEAD);
    chk("ill_err", last_err, 1);
    push(1, 3'd2, 8'hF0, 8'h3C);
    wait_resp(base + 2);
    chk("and_res", last_res, 16'h0030);
    chk("and_err", last_err, 0);
    // reset while the operation is in CAPTURE
    base = resp_cnt;
    push(2, 3'd5, 8'h03, 8'h04);
    k = 0;
    while (sb.size() == 0 && k < 50) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("mid_acc", sb.size(), 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    for (int i = 0; i < N; i++) stim[i].delete();
    repeat (2) @(negedge clk);
    #1 chk_zero("midrst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #1 chk("mid_norsp", resp_cnt, base);
    grant_log.delete();
    push(0, 3'd0, 8'h01, 8'h02);
    push(3, 3'd0, 8'h03, 8'h04);
    wait_resp(base + 2);
    chk("post_n", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      chk("post_first", grant_log[0], 0);
      chk("post_second", grant_log[1], 3);
    end
    // last grant is 3: requester 1 wraps ahead of 3
    grant_log.delete();
    push(1, 3'd3, 8'h0F, 8'hF0);
    push(3, 3'd4, 8'h0F, 8'hFF);
    wait_resp(base + 4);
    chk("wrap_n", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      chk("wrap_first", grant_log[0], 1);
      chk("wrap_second", grant_log[1], 3);
    end
    // random traffic with random response backpressure
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk);
      #1 bus.rsp_ready = N'($urandom) | N'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        ri = $urandom_range(0, N - 1);
        if (stim[ri].size() < 3) push(ri, 3'($urandom), 8'($urandom), 8'($urandom));
      end
    end
    bus.rsp_ready = '1;
    k = 0;
    while ((inflight || stim[0].size() + stim[1].size() + stim[2].size() + stim[3].size() > 0) && k < 500) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("drain", inflight || stim[0].size() + stim[1].size() + stim[2].size() + stim[3].size() > 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
